// File: rtl/dt_pkg.sv
// Shared types and sizing for the pipelined decision-tree classifier.
// Node words, actions and the per-stage pipeline payload live here.
package dt_pkg;

   localparam int NUM_FEATURES    = 4;
   localparam int FEAT_W          = 8;
   localparam int MAX_DEPTH       = 4;
   localparam int NODES_PER_LEVEL = 8;
   localparam int TAG_W           = 4;
   localparam int LVL_W           = $clog2(MAX_DEPTH);
   localparam int IDX_W           = $clog2(NODES_PER_LEVEL);
   localparam int FSEL_W          = $clog2(NUM_FEATURES);
   localparam int DEPTH_W         = LVL_W + 1;
   localparam int FVEC_W          = NUM_FEATURES * FEAT_W;

   typedef enum logic [1:0] {
      ACT_NONE   = 2'b00,
      ACT_BUY    = 2'b01,
      ACT_SELL   = 2'b10,
      ACT_CANCEL = 2'b11
   } dt_action_e;

   typedef struct packed {
      logic              is_leaf;
      logic [FSEL_W-1:0] feat_sel;
      logic [FEAT_W-1:0] threshold;
      logic              less_than;
      logic [IDX_W-1:0]  left_idx;
      logic [IDX_W-1:0]  right_idx;
      dt_action_e        action;
   } dt_node_t;

   localparam int NODE_W = $bits(dt_node_t);

   typedef struct packed {
      logic               valid;
      logic               done;
      logic [IDX_W-1:0]   idx;
      dt_action_e         action;
      logic [DEPTH_W-1:0] depth;
      logic               err;
      logic [TAG_W-1:0]   tag;
      logic [FVEC_W-1:0]  features;
   } dt_stage_t;

   // Out-of-range selectors fall back to feature 0.
   function automatic logic [FEAT_W-1:0] select_feature(
      input logic [FVEC_W-1:0] features,
      input logic [FSEL_W-1:0] sel
   );
      logic [FEAT_W-1:0] feat;
      feat = features[FEAT_W-1:0];
      for (int f = 1; f < NUM_FEATURES; f++) begin
         if (sel == FSEL_W'(f)) begin
            feat = features[f*FEAT_W +: FEAT_W];
         end
      end
      return feat;
   endfunction

   function automatic logic split_cond(
      input logic [FEAT_W-1:0] feat,
      input logic [FEAT_W-1:0] thr,
      input logic              less_than
   );
      return less_than ? (feat < thr) : (feat > thr);
   endfunction

endpackage

// File: rtl/dt_level_stage.sv
// One tree level: a node bank, the compare/select for the carried index, and the
// pipeline register feeding the next level.
module dt_level_stage
   import dt_pkg::*;
#(
   parameter int LEVEL = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  dt_stage_t         stage_in,
   output dt_stage_t         stage_q,
   input  logic              sw_we,
   input  logic [LVL_W-1:0]  sw_level,
   input  logic [IDX_W-1:0]  sw_addr,
   input  logic [NODE_W-1:0] sw_node
);

   logic [NODE_W-1:0] bank [NODES_PER_LEVEL];
   dt_node_t          node;
   logic [FEAT_W-1:0] feat;
   logic              cond;
   dt_stage_t         stage_d;

   // Bank has no reset; software must program every slot it expects to reach.
   always_ff @(posedge clk) begin
      if (sw_we && (sw_level == LVL_W'(LEVEL)) && (int'(sw_addr) < NODES_PER_LEVEL)) begin
         bank[sw_addr] <= sw_node;
      end
   end

   assign node = dt_node_t'(bank[stage_in.idx]);
   assign feat = select_feature(stage_in.features, node.feat_sel);
   assign cond = split_cond(feat, node.threshold, node.less_than);

   always_comb begin
      stage_d = stage_in;
      if (stage_in.valid && !stage_in.done) begin
         if (node.is_leaf) begin
            stage_d.done   = 1'b1;
            stage_d.action = node.action;
            stage_d.depth  = DEPTH_W'(LEVEL);
         end else if (LEVEL == MAX_DEPTH - 1) begin
            stage_d.done   = 1'b1;
            stage_d.action = node.action;
            stage_d.depth  = DEPTH_W'(LEVEL);
            stage_d.err    = 1'b1;
         end else begin
            stage_d.idx = cond ? node.left_idx : node.right_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else if (!stall) begin
         stage_q <= stage_d;
      end
   end

endmodule

// File: rtl/decision_tree_pipe.sv
// Fully pipelined decision-tree classifier, one stage per tree level, global stall.
// Define DT_PERF_CNT_EN to build the completed-result and stall-cycle counters.
module decision_tree_pipe
   import dt_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [FVEC_W-1:0]   in_features,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [1:0]          out_action,
   output logic [TAG_W-1:0]    out_tag,
   output logic [DEPTH_W-1:0]  out_depth,
   output logic                out_err,
   output logic                busy,
   input  logic                sw_we,
   input  logic [LVL_W-1:0]    sw_level,
   input  logic [IDX_W-1:0]    sw_addr,
   input  logic [NODE_W-1:0]   sw_node,
   output logic [31:0]         perf_done_cnt,
   output logic [31:0]         perf_stall_cnt
);

   logic      stall;
   dt_stage_t head_req;
   dt_stage_t stage_in [MAX_DEPTH];
   dt_stage_t stage_q  [MAX_DEPTH];
   dt_stage_t last;
   logic      unused_last;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   always_comb begin
      head_req          = '0;
      head_req.valid    = in_valid;
      head_req.tag      = in_tag;
      head_req.features = in_features;
   end

   for (genvar g = 0; g < MAX_DEPTH; g++) begin : g_level
      if (g == 0) begin : g_head
         assign stage_in[g] = head_req;
      end else begin : g_chain
         assign stage_in[g] = stage_q[g-1];
      end

      dt_level_stage #(.LEVEL(g)) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .stall    (stall),
         .stage_in (stage_in[g]),
         .stage_q  (stage_q[g]),
         .sw_we    (sw_we),
         .sw_level (sw_level),
         .sw_addr  (sw_addr),
         .sw_node  (sw_node)
      );
   end

   assign last        = stage_q[MAX_DEPTH-1];
   assign unused_last = ^{last.done, last.idx, last.features};

   // Result fields only reload with a valid request so they stay put across bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_action <= 2'b00;
         out_tag    <= '0;
         out_depth  <= '0;
         out_err    <= 1'b0;
      end else if (!stall) begin
         out_valid <= last.valid;
         if (last.valid) begin
            out_action <= last.action;
            out_tag    <= last.tag;
            out_depth  <= last.depth;
            out_err    <= last.err;
         end
      end
   end

   always_comb begin
      busy = out_valid;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         busy = busy | stage_q[i].valid;
      end
   end

`ifdef DT_PERF_CNT_EN
   logic [31:0] done_cnt;
   logic [31:0] stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (out_valid && out_ready) begin
            done_cnt <= done_cnt + 32'd1;
         end
         if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end

   assign perf_done_cnt  = done_cnt;
   assign perf_stall_cnt = stall_cnt;
`else
   assign perf_done_cnt  = '0;
   assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_decision_tree_pipe.sv
// Directed self-checking bench for decision_tree_pipe: split, streaming,
// backpressure, reset, depth overrun and performance counters.
module tb_decision_tree_pipe;
   import dt_pkg::*;

   logic                clk;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [FVEC_W-1:0]   in_features;
   logic [TAG_W-1:0]    in_tag;
   logic                out_valid;
   logic                out_ready;
   logic [1:0]          out_action;
   logic [TAG_W-1:0]    out_tag;
   logic [DEPTH_W-1:0]  out_depth;
   logic                out_err;
   logic                busy;
   logic                sw_we;
   logic [LVL_W-1:0]    sw_level;
   logic [IDX_W-1:0]    sw_addr;
   logic [NODE_W-1:0]   sw_node;
   logic [31:0]         perf_done_cnt;
   logic [31:0]         perf_stall_cnt;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   int qTag [$];
   int qAct [$];
   int qCyc [$];

   logic [FVEC_W-1:0] reqFeat [16];
   logic [TAG_W-1:0]  reqTag  [16];
   int                expAct  [16];

   decision_tree_pipe dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_features    (in_features),
      .in_tag         (in_tag),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_action     (out_action),
      .out_tag        (out_tag),
      .out_depth      (out_depth),
      .out_err        (out_err),
      .busy           (busy),
      .sw_we          (sw_we),
      .sw_level       (sw_level),
      .sw_addr        (sw_addr),
      .sw_node        (sw_node),
      .perf_done_cnt  (perf_done_cnt),
      .perf_stall_cnt (perf_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Record every handshake that will complete at the coming rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         qTag.push_back(int'(out_tag));
         qAct.push_back(int'(out_action));
         qCyc.push_back(cycle);
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, obs, exp);
      end
   endtask

   function automatic dt_node_t mkNode(input logic leaf, input logic [FSEL_W-1:0] fsel,
                                       input logic [FEAT_W-1:0] thr, input logic lt,
                                       input logic [IDX_W-1:0] l, input logic [IDX_W-1:0] r,
                                       input dt_action_e act);
      dt_node_t n;
      n.is_leaf   = leaf;
      n.feat_sel  = fsel;
      n.threshold = thr;
      n.less_than = lt;
      n.left_idx  = l;
      n.right_idx = r;
      n.action    = act;
      return n;
   endfunction

   task automatic writeNode(input logic [LVL_W-1:0] lvl, input logic [IDX_W-1:0] addr, input dt_node_t n);
      sw_we    = 1'b1;
      sw_level = lvl;
      sw_addr  = addr;
      sw_node  = n;
      @(posedge clk); #1;
      sw_we    = 1'b0;
   endtask

   task automatic clearQueues();
      qTag.delete();
      qAct.delete();
      qCyc.delete();
   endtask

   // One isolated request: checks acceptance, 4-edge latency and the result fields.
   task automatic runSingle(input logic [FVEC_W-1:0] feat, input logic [TAG_W-1:0] tag,
                            input logic [1:0] act, input logic [DEPTH_W-1:0] depth,
                            input logic err, input string name);
      in_valid    = 1'b1;
      in_features = feat;
      in_tag      = tag;
      @(negedge clk);
      checkOutput({name, "_in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput({name, "_not_early"}, out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, "_valid"}, out_valid, 1);
      checkOutput({name, "_action"}, out_action, act);
      checkOutput({name, "_tag"}, out_tag, tag);
      checkOutput({name, "_depth"}, out_depth, depth);
      checkOutput({name, "_err"}, out_err, err);
      @(posedge clk); #1;
   endtask

   // Streams reqFeat/reqTag[0..n-1]; out_ready is low for stallLen cycles from stallFrom.
   task automatic applyStimulus(input int n, input int stallFrom, input int stallLen);
      int k = 0;
      int cyc = 0;
      int stallEnd;
      logic acc;
      logic [31:0] held = '0;
      stallEnd = (stallLen > 0) ? stallFrom + stallLen : 0;
      while ((k < n || cyc < stallEnd) && cyc < 200) begin
         in_valid    = (k < n);
         in_features = reqFeat[(k < n) ? k : 0];
         in_tag      = reqTag[(k < n) ? k : 0];
         out_ready   = !(cyc >= stallFrom && cyc < stallEnd);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (!out_ready) begin
            checkOutput("stall_in_ready", in_ready, 0);
            checkOutput("stall_out_valid", out_valid, 1);
            if (cyc == stallFrom) begin
               held = 32'({out_tag, out_action, out_depth, out_err});
            end else begin
               checkOutput("stall_hold", 32'({out_tag, out_action, out_depth, out_err}), held);
            end
         end
         @(posedge clk); #1;
         if (acc) k++;
         cyc++;
      end
      checkOutput("stream_accepts", k, n);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_features = '0;
      in_tag      = '0;
      out_ready   = 1'b1;
      sw_we       = 1'b0;
      sw_level    = '0;
      sw_addr     = '0;
      sw_node     = '0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_in_ready", in_ready, 1);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done_cnt", perf_done_cnt, 0);
      checkOutput("reset_stall_cnt", perf_stall_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int l = 0; l < MAX_DEPTH; l++) begin
         for (int a = 0; a < NODES_PER_LEVEL; a++) begin
            writeNode(LVL_W'(l), IDX_W'(a), '0);
         end
      end

      // Test 1: basic split on feature 0 at threshold 100
      writeNode(2'd0, 3'd0, mkNode(1'b0, 2'd0, 8'd100, 1'b1, 3'd0, 3'd1, ACT_NONE));
      writeNode(2'd1, 3'd0, mkNode(1'b1, 2'd0, 8'd0, 1'b0, 3'd0, 3'd0, ACT_BUY));
      writeNode(2'd1, 3'd1, mkNode(1'b1, 2'd0, 8'd0, 1'b0, 3'd0, 3'd0, ACT_SELL));
      runSingle(32'd50, 4'd3, 2'b01, 3'd1, 1'b0, "t1_buy");
      runSingle(32'd100, 4'd5, 2'b10, 3'd1, 1'b0, "t1_equal_sell");

      // Test 2: 8 back-to-back requests
      clearQueues();
      for (int i = 0; i < 8; i++) begin
         reqTag[i]  = TAG_W'(i);
         reqFeat[i] = (i % 2 == 0) ? 32'd50 : 32'd150;
         expAct[i]  = (i % 2 == 0) ? 1 : 2;
      end
      applyStimulus(8, 0, 0);
      checkOutput("t2_count", qTag.size(), 8);
      for (int i = 0; i < 8 && i < qTag.size(); i++) begin
         checkOutput("t2_tag", qTag[i], i);
         checkOutput("t2_action", qAct[i], expAct[i]);
         checkOutput("t2_back_to_back", qCyc[i] - qCyc[0], i);
      end

      // Test 3: 5 cycles of backpressure mid-stream
      clearQueues();
      for (int i = 0; i < 8; i++) begin
         reqTag[i]  = TAG_W'(i);
         reqFeat[i] = (i < 4) ? 32'd99 : 32'd100;
         expAct[i]  = (i < 4) ? 1 : 2;
      end
      applyStimulus(8, 5, 5);
      checkOutput("t3_count", qTag.size(), 8);
      for (int i = 0; i < 8 && i < qTag.size(); i++) begin
         checkOutput("t3_tag", qTag[i], i);
         checkOutput("t3_action", qAct[i], expAct[i]);
      end

      // Test 4: reset with 3 requests in flight
      clearQueues();
      for (int i = 0; i < 3; i++) begin
         in_valid    = 1'b1;
         in_tag      = TAG_W'(i);
         in_features = 32'd50;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checkOutput("t4_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("t4_out_valid", out_valid, 0);
      checkOutput("t4_busy", busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("t4_no_result", qTag.size(), 0);
      checkOutput("t4_in_ready", in_ready, 1);

      // Test 5: non-leaf chain to the last level, then a leaf at the last level
      writeNode(2'd0, 3'd0, mkNode(1'b0, 2'd1, 8'd10, 1'b0, 3'd2, 3'd3, ACT_NONE));
      writeNode(2'd1, 3'd2, mkNode(1'b0, 2'd2, 8'd200, 1'b1, 3'd4, 3'd5, ACT_NONE));
      writeNode(2'd2, 3'd4, mkNode(1'b0, 2'd3, 8'd7, 1'b0, 3'd6, 3'd7, ACT_NONE));
      writeNode(2'd3, 3'd7, mkNode(1'b0, 2'd0, 8'd0, 1'b0, 3'd0, 3'd0, ACT_CANCEL));
      writeNode(2'd3, 3'd6, mkNode(1'b1, 2'd0, 8'd0, 1'b0, 3'd0, 3'd0, ACT_SELL));
      runSingle(32'h07051400, 4'd9, 2'b11, 3'd3, 1'b1, "t5_overrun");
      runSingle(32'h08051400, 4'd10, 2'b10, 3'd3, 1'b0, "t5_leaf_l3");

      // Test 6: 10 results with 3 stall cycles after a fresh reset
      writeNode(2'd0, 3'd0, mkNode(1'b0, 2'd0, 8'd100, 1'b1, 3'd0, 3'd1, ACT_NONE));
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      clearQueues();
      for (int i = 0; i < 10; i++) begin
         reqTag[i]  = TAG_W'(i);
         reqFeat[i] = 32'd50;
      end
      applyStimulus(10, 5, 3);
      checkOutput("t6_count", qTag.size(), 10);
      for (int i = 0; i < 10 && i < qTag.size(); i++) begin
         checkOutput("t6_tag", qTag[i], i);
      end
`ifdef DT_PERF_CNT_EN
      checkOutput("t6_done_cnt", perf_done_cnt, 10);
      checkOutput("t6_stall_cnt", perf_stall_cnt, 3);
`else
      checkOutput("t6_done_cnt", perf_done_cnt, 0);
      checkOutput("t6_stall_cnt", perf_stall_cnt, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
